// File: rtl/tug_referee_if.sv
// Player/display-facing bundle of the tug-of-war referee: push/tick inputs and rope/score outputs.
// Handshake: none; every input is a level sampled on the rising clk edge, and every output is a registered level.
interface tug_referee_if #(
  parameter int ROPE_HALF = 3
);
  logic                   slowen;
  logic                   pushL;
  logic                   pushR;
  logic                   new_game;
  logic [2*ROPE_HALF:0]   rope_led;
  logic [6:0]             scoreL;
  logic [6:0]             scoreR;
  logic [6:0]             score;
  logic                   isVictory;
  logic                   winner;
  logic                   round_done;
  logic [1:0]             state_dbg;

  modport master (
    output slowen, pushL, pushR, new_game,
    input  rope_led, scoreL, scoreR, score, isVictory, winner, round_done, state_dbg
  );

  modport slave (
    input  slowen, pushL, pushR, new_game,
    output rope_led, scoreL, scoreR, score, isVictory, winner, round_done, state_dbg
  );
endinterface

// File: rtl/tug_referee.sv
// Tug-of-war game core: moves the rope on push pulses, scores rounds, holds the cheer
// display for CHEER_TICKS slow ticks and latches the overall victory.
module tug_referee #(
  parameter int ROPE_HALF   = 3,
  parameter int WIN_ROUNDS  = 3,
  parameter int CHEER_TICKS = 8
) (
  input  logic          clk,
  input  logic          rst,
  tug_referee_if.slave  bus
);
  localparam int LW = 2*ROPE_HALF + 1;
  localparam int PW = $clog2(ROPE_HALF + 1) + 1;
  localparam logic signed [PW-1:0] POS_MAX = PW'(ROPE_HALF);
  localparam logic signed [PW-1:0] POS_MIN = -POS_MAX;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    ROUND_END = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic signed [PW-1:0]   pos, pos_n;
  logic [2:0]             cnt_l, cnt_l_n, cnt_r, cnt_r_n;
  logic [7:0]             cheer, cheer_n;
  logic                   win, win_n;

  logic [LW-1:0]          rope;
  logic [6:0]             therm_l, therm_r, score_o;
  logic                   victory_o, round_done_o;

  // Thermometer of a round count; 7 rounds sets all bits.
  function automatic logic [6:0] therm(input logic [2:0] c);
    return ~(7'h7f << c);
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] c);
    return (c == 3'd7) ? c : c + 3'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PLAY;
      pos   <= '0;
      cnt_l <= '0;
      cnt_r <= '0;
      cheer <= '0;
      win   <= 1'b0;
    end else begin
      state <= state_n;
      pos   <= pos_n;
      cnt_l <= cnt_l_n;
      cnt_r <= cnt_r_n;
      cheer <= cheer_n;
      win   <= win_n;
    end
  end

  always_comb begin
    state_n = state;
    pos_n   = pos;
    cnt_l_n = cnt_l;
    cnt_r_n = cnt_r;
    cheer_n = cheer;
    win_n   = win;
    if (bus.new_game) begin
      state_n = PLAY;
      pos_n   = '0;
      cnt_l_n = '0;
      cnt_r_n = '0;
      cheer_n = '0;
    end else begin
      case (state)
        PLAY: begin
          if (bus.pushL && !bus.pushR) pos_n = pos - PW'(1);
          else if (bus.pushR && !bus.pushL) pos_n = pos + PW'(1);
          // A round ends only on a move that lands on an end stop.
          if (bus.pushL != bus.pushR) begin
            if (pos_n == POS_MIN) begin
              cnt_l_n = sat_inc(cnt_l);
              win_n   = 1'b0;
              state_n = ROUND_END;
              cheer_n = '0;
            end else if (pos_n == POS_MAX) begin
              cnt_r_n = sat_inc(cnt_r);
              win_n   = 1'b1;
              state_n = ROUND_END;
              cheer_n = '0;
            end
          end
        end
        ROUND_END: begin
          if (bus.slowen) begin
            cheer_n = cheer + 8'd1;
            if (cheer_n == 8'(CHEER_TICKS)) begin
              cheer_n = '0;
              if ((win ? cnt_r : cnt_l) == 3'(WIN_ROUNDS)) begin
                state_n = GAME_OVER;
              end else begin
                state_n = PLAY;
                pos_n   = '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rope = '0;
    for (int i = 0; i < LW; i++) begin
      rope[i] = (pos == $signed(PW'(i - ROPE_HALF)));
    end
    therm_l      = therm(cnt_l);
    therm_r      = therm(cnt_r);
    victory_o    = (state == GAME_OVER);
    round_done_o = (state == ROUND_END);
    score_o      = victory_o ? (win ? therm_r : therm_l) : 7'd0;
  end

  assign bus.rope_led   = rope;
  assign bus.scoreL     = therm_l;
  assign bus.scoreR     = therm_r;
  assign bus.score      = score_o;
  assign bus.isVictory  = victory_o;
  assign bus.winner     = win;
  assign bus.round_done = round_done_o;
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_tug_referee.sv
// Self-checking bench for tug_referee: a game-rule reference model predicts each cycle's
// outputs into a queue that is compared against the DUT after every clock edge.
module tb_tug_referee;
  logic clk = 1'b0;
  logic rst = 1'b0;

  tug_referee_if #(.ROPE_HALF(3)) bus ();

  tug_referee #(.ROPE_HALF(3), .WIN_ROUNDS(3), .CHEER_TICKS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [30:0] exp_q[$];

  // Reference game state: 0 play, 1 round end, 2 game over.
  int m_state, m_pos, m_cl, m_cr, m_cheer;
  bit m_win;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Snapshot: {rope, scoreL, scoreR, score, isVictory, winner(when valid), round_done}
  function automatic logic [30:0] dut_snap();
    logic v;
    v = bus.isVictory | bus.round_done;
    return {bus.rope_led, bus.scoreL, bus.scoreR, bus.score, bus.isVictory,
            bus.winner & v, bus.round_done};
  endfunction

  function automatic logic [30:0] model_snap();
    logic [6:0] rope, sl, sr, sc;
    logic isv, rd;
    rope = 7'(1 << (m_pos + 3));
    sl   = 7'((1 << m_cl) - 1);
    sr   = 7'((1 << m_cr) - 1);
    isv  = (m_state == 2);
    rd   = (m_state == 1);
    sc   = isv ? (m_win ? sr : sl) : 7'd0;
    return {rope, sl, sr, sc, isv, m_win & (isv | rd), rd};
  endfunction

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_cl = 0; m_cr = 0; m_cheer = 0; m_win = 0;
  endtask

  task automatic model_step(input bit pl, input bit pr, input bit sl, input bit ng);
    if (ng) begin
      m_state = 0; m_pos = 0; m_cl = 0; m_cr = 0; m_cheer = 0;
    end else if (m_state == 0) begin
      if (pl && !pr) m_pos--;
      if (pr && !pl) m_pos++;
      if (m_pos == -3) begin
        if (m_cl < 7) m_cl++;
        m_win = 0; m_state = 1; m_cheer = 0;
      end else if (m_pos == 3) begin
        if (m_cr < 7) m_cr++;
        m_win = 1; m_state = 1; m_cheer = 0;
      end
    end else if (m_state == 1 && sl) begin
      m_cheer++;
      if (m_cheer == 8) begin
        if ((m_win ? m_cr : m_cl) == 3) m_state = 2;
        else begin m_state = 0; m_pos = 0; end
      end
    end
  endtask

  // Drive one cycle of inputs, predict, then compare one edge later.
  task automatic cycle(input bit pl, input bit pr, input bit sl, input bit ng);
    bus.pushL = pl; bus.pushR = pr; bus.slowen = sl; bus.new_game = ng;
    model_step(pl, pr, sl, ng);
    exp_q.push_back(model_snap());
    @(posedge clk); #1;
    check("cycle", {1'b0, dut_snap()}, {1'b0, exp_q.pop_front()});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic cheer_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);
    end
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst = 1'b1;
    model_reset();
    exp_q.push_back(model_snap());
    #1 check(tag, {1'b0, dut_snap()}, {1'b0, exp_q.pop_front()});
    check({tag, "_rope"}, {25'd0, bus.rope_led}, 32'b0001000);
  endtask

  initial begin
    bus.pushL = 0; bus.pushR = 0; bus.slowen = 0; bus.new_game = 0;
    model_reset();

    // Reset asserted between edges must clear everything at once.
    #1;
    async_reset_check("reset_async");
    @(posedge clk); #1;
    rst = 1'b0;

    cycle(1, 0, 0, 0);
    check("rope_after_pushL", {25'd0, bus.rope_led}, 32'b0000100);
    idle(2);
    cycle(0, 1, 0, 0);
    check("rope_after_pushR", {25'd0, bus.rope_led}, 32'b0001000);

    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
    check("both_push_rope", {25'd0, bus.rope_led}, 32'b0001000);

    // Right wins a round.
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    check("round_done_R", {31'd0, bus.round_done}, 32'd1);
    check("rope_right_end", {25'd0, bus.rope_led}, 32'b1000000);
    check("scoreR_1", {25'd0, bus.scoreR}, 32'b0000001);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cheer_ticks(7);
    check("still_cheering", {31'd0, bus.round_done}, 32'd1);
    cheer_ticks(1);
    check("recentre_rope", {25'd0, bus.rope_led}, 32'b0001000);
    check("recentre_rd", {31'd0, bus.round_done}, 32'd0);

    // Left takes three rounds and the game.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
      cheer_ticks(8);
    end
    check("victory", {31'd0, bus.isVictory}, 32'd1);
    check("victory_score", {25'd0, bus.score}, 32'b0000111);
    check("victory_scoreL", {25'd0, bus.scoreL}, 32'b0000111);
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0);
    cycle(0, 1, 1, 0);
    check("victory_hold", {31'd0, bus.isVictory}, 32'd1);

    cycle(0, 0, 0, 1);
    check("newgame_over", {25'd0, bus.score}, 32'd0);

    // new_game mid-play at pos=+2, beating a simultaneous push.
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check("pos_plus2", {25'd0, bus.rope_led}, 32'b0100000);
    cycle(1, 0, 0, 1);
    check("newgame_play", {25'd0, bus.rope_led}, 32'b0001000);

    // Random play.
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 2) == 0),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 60) == 0));
    end

    // Reset in the middle of a cheer hold.
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    cheer_ticks(5);
    async_reset_check("reset_in_cheer");
    #2 rst = 1'b0;
    for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0);
    check("no_early_round", {31'd0, bus.round_done}, 32'd0);
    cycle(0, 1, 0, 0);
    cheer_ticks(7);
    check("full_cheer_needed", {31'd0, bus.round_done}, 32'd1);
    cheer_ticks(1);
    check("after_cheer_scoreR", {25'd0, bus.scoreR}, 32'b0000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
